// File: rtl/bwt_occ_responder_if.sv
// Bus bundle for bwt_occ_responder: request port from the backward stage,
// memory read request/response channel, and the occurrence-count response.
// The slave modport is the responder's view; master is the environment's view.
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 6
`endif

interface bwt_occ_responder_if #(
    parameter int ADDR_W = 42,
    parameter int LINE_W = 512
);
    // pipeline control
    logic                        stall;

    // request port
    logic                        req_valid;
    logic [ADDR_W-1:0]           req_addr_k;
    logic [ADDR_W-1:0]           req_addr_l;
    logic [`READ_NUM_WIDTH-1:0]  req_read_num;
    logic                        req_almost_full;
    logic                        err_overflow;

    // memory read channel
    logic                        mem_rd_valid;
    logic [ADDR_W-1:0]           mem_rd_addr;
    logic                        mem_rd_ready;
    logic                        mem_rsp_valid;
    logic [LINE_W-1:0]           mem_rsp_data;

    // occurrence response
    logic                        rsp_valid;
    logic [`READ_NUM_WIDTH-1:0]  rsp_read_num;
    logic [31:0]                 cnt_a0, cnt_a1, cnt_a2, cnt_a3;
    logic [63:0]                 cnt_b0, cnt_b1, cnt_b2, cnt_b3;
    logic [31:0]                 cntl_a0, cntl_a1, cntl_a2, cntl_a3;
    logic [63:0]                 cntl_b0, cntl_b1, cntl_b2, cntl_b3;

    modport slave (
        input  stall,
        input  req_valid, req_addr_k, req_addr_l, req_read_num,
        output req_almost_full, err_overflow,
        output mem_rd_valid, mem_rd_addr,
        input  mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_valid, rsp_read_num,
        output cnt_a0, cnt_a1, cnt_a2, cnt_a3,
        output cnt_b0, cnt_b1, cnt_b2, cnt_b3,
        output cntl_a0, cntl_a1, cntl_a2, cntl_a3,
        output cntl_b0, cntl_b1, cntl_b2, cntl_b3
    );

    modport master (
        output stall,
        output req_valid, req_addr_k, req_addr_l, req_read_num,
        input  req_almost_full, err_overflow,
        input  mem_rd_valid, mem_rd_addr,
        output mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_valid, rsp_read_num,
        input  cnt_a0, cnt_a1, cnt_a2, cnt_a3,
        input  cnt_b0, cnt_b1, cnt_b2, cnt_b3,
        input  cntl_a0, cntl_a1, cntl_a2, cntl_a3,
        input  cntl_b0, cntl_b1, cntl_b2, cntl_b3
    );
endinterface

// File: rtl/bwt_occ_responder.sv
// bwt_occ_responder: queues {addr_k, addr_l, read_num} requests, fetches the
// k and l occurrence lines from memory one pair at a time, and presents the
// a/b counts of both lines to the backward pipeline with a stall-held response.
// Optional feature macro: SAME_LINE_MERGE_EN -- when defined, a pair whose k
// and l addresses match is served with a single memory read whose line feeds
// both the cnt_* and cntl_* outputs.
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 6
`endif

module bwt_occ_responder #(
    parameter int ADDR_W    = 42,
    parameter int REQ_DEPTH = 8,
    parameter int LINE_W    = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    bwt_occ_responder_if.slave   bus
);
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int RN_W  = `READ_NUM_WIDTH;
    localparam int ENT_W = 2 * ADDR_W + RN_W;
    // only the low 384 bits of a line carry counts (4x32b a, 4x64b b)
    localparam int CNT_W = 384;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(REQ_DEPTH);
    localparam logic [PTR_W:0]   CNT_AF   = (PTR_W+1)'(REQ_DEPTH - 2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_K,
        ISSUE_L,
        WAIT_K,
        WAIT_L,
        RESP
    } state_t;

    // request FIFO
    logic [ENT_W-1:0]  fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              err_overflow_q;

    // pair in flight
    logic [ADDR_W-1:0] cur_k_q;
    logic [ADDR_W-1:0] cur_l_q;
    logic [RN_W-1:0]   cur_tag_q;
    logic              k_done_q;
    logic [CNT_W-1:0]  k_buf_q;

    // response registers
    logic [CNT_W-1:0]  out_k_q;
    logic [CNT_W-1:0]  out_l_q;
    logic [RN_W-1:0]   out_tag_q;

    // FSM
    state_t            state_q;
    state_t            state_d;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              latch_k;
    logic              latch_l;
    logic              latch_both;
    logic [CNT_W-1:0]  rsp_line;

    assign rsp_line   = bus.mem_rsp_data[CNT_W-1:0];

    generate
        if (LINE_W > CNT_W) begin : g_spare_bits
            logic unused_rsp_bits;
            assign unused_rsp_bits = ^bus.mem_rsp_data[LINE_W-1:CNT_W];
        end
    endgenerate

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    // full is judged before this cycle's pop, so a push into a full FIFO is
    // dropped even if the FSM frees a slot in the same cycle
    assign push       = bus.req_valid && !fifo_full;
    assign pop        = (state_q == IDLE) && !fifo_empty;

`ifdef SAME_LINE_MERGE_EN
    logic same_line;
    assign same_line = (cur_k_q == cur_l_q);
`endif

    // FIFO storage: data path only, contents are qualified by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.req_addr_k, bus.req_addr_l, bus.req_read_num};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo REQ_DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // sticky overflow flag: a request arrived while every slot was occupied
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_overflow_q <= 1'b0;
        end else if (bus.req_valid && fifo_full) begin
            err_overflow_q <= 1'b1;
        end
    end

    // capture the popped pair and track whether its k line already arrived
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_k_q   <= '0;
            cur_l_q   <= '0;
            cur_tag_q <= '0;
            k_done_q  <= 1'b0;
        end else if (pop) begin
            {cur_k_q, cur_l_q, cur_tag_q} <= fifo_mem[rd_ptr_q];
            k_done_q                      <= 1'b0;
        end else if (latch_k) begin
            k_done_q <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, memory request and line-capture strobes
    always_comb begin
        state_d    = state_q;
        rd_valid   = 1'b0;
        rd_addr    = cur_k_q;
        latch_k    = 1'b0;
        latch_l    = 1'b0;
        latch_both = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE_K;
                end
            end
            ISSUE_K: begin
                rd_valid = 1'b1;
                if (bus.mem_rd_ready) begin
`ifdef SAME_LINE_MERGE_EN
                    state_d = same_line ? WAIT_K : ISSUE_L;
`else
                    state_d = ISSUE_L;
`endif
                end
            end
            ISSUE_L: begin
                rd_valid = 1'b1;
                rd_addr  = cur_l_q;
                // a fast memory may return the k line while l is still being issued
                latch_k  = bus.mem_rsp_valid;
                if (bus.mem_rd_ready) begin
                    state_d = (k_done_q || bus.mem_rsp_valid) ? WAIT_L : WAIT_K;
                end
            end
            WAIT_K: begin
                if (bus.mem_rsp_valid) begin
`ifdef SAME_LINE_MERGE_EN
                    if (same_line) begin
                        latch_both = 1'b1;
                        state_d    = RESP;
                    end else begin
                        latch_k = 1'b1;
                        state_d = WAIT_L;
                    end
`else
                    latch_k = 1'b1;
                    state_d = WAIT_L;
`endif
                end
            end
            WAIT_L: begin
                if (bus.mem_rsp_valid) begin
                    latch_l = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!bus.stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // k line holding buffer until the l line completes the pair
    always_ff @(posedge clk) begin
        if (latch_k) begin
            k_buf_q <= rsp_line;
        end
    end

    // response registers load only when a pair completes, so they hold
    // their last value through stalls and while no response is pending
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_k_q   <= '0;
            out_l_q   <= '0;
            out_tag_q <= '0;
        end else if (latch_l) begin
            out_k_q   <= k_buf_q;
            out_l_q   <= rsp_line;
            out_tag_q <= cur_tag_q;
        end else if (latch_both) begin
            out_k_q   <= rsp_line;
            out_l_q   <= rsp_line;
            out_tag_q <= cur_tag_q;
        end
    end

    assign bus.req_almost_full = (count_q >= CNT_AF);
    assign bus.err_overflow    = err_overflow_q;
    assign bus.mem_rd_valid    = rd_valid;
    assign bus.mem_rd_addr     = rd_addr;
    assign bus.rsp_valid       = (state_q == RESP);
    assign bus.rsp_read_num    = out_tag_q;

    assign bus.cnt_a0  = out_k_q[31:0];
    assign bus.cnt_a1  = out_k_q[63:32];
    assign bus.cnt_a2  = out_k_q[95:64];
    assign bus.cnt_a3  = out_k_q[127:96];
    assign bus.cnt_b0  = out_k_q[191:128];
    assign bus.cnt_b1  = out_k_q[255:192];
    assign bus.cnt_b2  = out_k_q[319:256];
    assign bus.cnt_b3  = out_k_q[383:320];

    assign bus.cntl_a0 = out_l_q[31:0];
    assign bus.cntl_a1 = out_l_q[63:32];
    assign bus.cntl_a2 = out_l_q[95:64];
    assign bus.cntl_a3 = out_l_q[127:96];
    assign bus.cntl_b0 = out_l_q[191:128];
    assign bus.cntl_b1 = out_l_q[255:192];
    assign bus.cntl_b2 = out_l_q[319:256];
    assign bus.cntl_b3 = out_l_q[383:320];

endmodule
